network_acc_requant_28s_16s: RTL and testbench
==============================================

NETWORK_ACC_REQUANT_28S_16S -- requirements
Module: network_acc_requant_28s_16s

Interface
REQ-001 The block SHALL have parameter NUM_TERMS, default 9, giving the products accumulated per output (legal range 1..256).
REQ-002 The block SHALL have parameter SHIFT, default 10, giving the fixed-point right shift applied after accumulation (legal range 1..16).
REQ-003 The block SHALL have parameter ACC_WIDTH, default 36, giving the signed accumulator width.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all logic on its rising edge.
REQ-005 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-006 The block SHALL have port ce, input, 1 bit: clock enable; when 0, all state freezes.
REQ-007 The block SHALL have port din, input, 28 bits: signed product from the 16s x 12ns multiplier.
REQ-008 The block SHALL have port din_valid, input, 1 bit: din holds a valid product.
REQ-009 The block SHALL have port din_ready, output, 1 bit: the block accepts din this cycle.
REQ-010 The block SHALL have port bias, input, 16 bits: signed bias, sampled with the first term of each group.
REQ-011 The block SHALL have port dout, output, 16 bits: signed requantised result.
REQ-012 The block SHALL have port dout_valid, output, 1 bit: dout holds a valid result.
REQ-013 The block SHALL have port dout_ready, input, 1 bit: the consumer takes dout this cycle.
REQ-014 The block SHALL have port sat, output, 1 bit: sticky flag, set whenever a result is clamped.

Function
REQ-015 The block SHALL implement a two-state FSM: ACCUM (din_ready=1, dout_valid=0) and EMIT (din_ready=0, dout_valid=1).
REQ-016 A term SHALL be accepted only when ce=1, din_valid=1 and the state is ACCUM.
REQ-017 The first accepted term of a group (term count 0) SHALL load acc with sign-extended din and latch bias; each later term SHALL add sign-extended din to acc.
REQ-018 The term counter SHALL run 0..NUM_TERMS-1 and wrap to 0 on the edge that accepts term NUM_TERMS-1; that edge SHALL register dout and move the FSM to EMIT.
REQ-019 On that edge the result SHALL be r = (acc + din + (bias <<< SHIFT) + 2^(SHIFT-1)) >>> SHIFT, computed in ACC_WIDTH bits: round half up, arithmetic shift.
REQ-020 The result r SHALL saturate to the range [-32768, 32767]; any clamp SHALL set sat, which stays 1 until reset.
REQ-021 dout_valid SHALL assert on the cycle after the last term is accepted, which gives a latency of 1 cycle.
REQ-022 In EMIT, dout SHALL stay stable until ce=1 and dout_ready=1; on that edge the FSM SHALL return to ACCUM.
REQ-023 No term SHALL be accepted on the handoff edge, so groups never overlap.
REQ-024 With ce=0, acc, the counter, the FSM, dout, dout_valid and sat SHALL all hold, and the handshake SHALL be ignored.
REQ-025 With NUM_TERMS=1, every accepted term SHALL produce one result.

Reset
REQ-026 When reset=1 on a rising edge, the block SHALL return to state ACCUM with counter=0, acc=0, dout=0, dout_valid=0 and sat=0, regardless of ce.
REQ-027 A reset during a partial group or during EMIT SHALL discard that group; the first term accepted after reset SHALL start a new group.

Configuration
REQ-028 When macro NETWORK_ACC_RELU_EN is defined, negative r SHALL become 0 before saturation, and that clamp SHALL NOT set sat.
REQ-029 Without NETWORK_ACC_RELU_EN, signed results SHALL pass through to saturation unchanged.

Structure
REQ-030 A shared package SHALL hold the width constants DIN_W=28, DOUT_W=16 and BIAS_W=16, the FSM state typedef (ACCUM, EMIT), and the saturation limit constants.
REQ-031 The rounding, shift, ReLU and saturation path SHALL be one combinational sub-module, network_requant_sat.

Verification (NUM_TERMS=3, SHIFT=10, bias=0 unless stated)
REQ-032 Terms 1024, 2048, 3072 with dout_ready=1 -> dout=6 and dout_valid=1 for exactly 1 cycle, the cycle after the third accept; sat=0.
REQ-033 Terms 512, 512, 512 (sum 1536) -> dout=2; terms -512, -512, -512 -> dout=-1 without ReLU and dout=0 with NETWORK_ACC_RELU_EN.
REQ-034 Terms 134217727 x3 -> dout=32767, sat=1; next group of 0, 0, 0 with bias=5 -> dout=5 and sat still 1.
REQ-035 Hold dout_ready=0 for 4 cycles after a result with din_valid=1 -> dout stable, din_ready=0 throughout, no term lost; the next group starts after the handoff.
REQ-036 Assert reset after 2 of 3 terms, then feed 1024, 1024, 1024 -> dout=3; toggling ce=0 mid-group stretches timing without changing the result.

Source files
------------

// File: rtl/network_acc_requant_28s_16s_pkg.sv
// ----------------------------------------------------------------------------
// network_acc_requant_28s_16s_pkg
// Shared constants and types for the accumulate/requantise block:
//   DIN_W / DOUT_W / BIAS_W : data path widths (product, result, bias)
//   SAT_MAX / SAT_MIN       : signed 16-bit clamp limits for the result
//   state_t                 : two-state handshake FSM (ACCUM, EMIT)
// ----------------------------------------------------------------------------
package network_acc_requant_28s_16s_pkg;

    localparam int DIN_W   = 28;
    localparam int DOUT_W  = 16;
    localparam int BIAS_W  = 16;

    localparam int SAT_MAX = 32767;
    localparam int SAT_MIN = -32768;

    typedef enum logic {
        ACCUM = 1'b0,
        EMIT  = 1'b1
    } state_t;

endpackage

// File: rtl/network_requant_sat.sv
// ----------------------------------------------------------------------------
// network_requant_sat
// Combinational requantiser: adds the round-half-up constant 2^(SHIFT-1),
// arithmetic-shifts right by SHIFT, optionally applies ReLU, then clamps
// to the signed 16-bit range.
//
// Optional feature macro: NETWORK_ACC_RELU_EN
//   defined   -> negative results become 0 (this clamp does not raise clamp)
//   undefined -> signed results go straight to saturation
//
// Ports:
//   sum    in  [ACC_WIDTH-1:0] signed  acc + last term + (bias <<< SHIFT)
//   result out [DOUT_W-1:0]            requantised, saturated value
//   clamp  out                         1 when the saturation stage clipped
// ----------------------------------------------------------------------------
module network_requant_sat
    import network_acc_requant_28s_16s_pkg::*;
#(
    parameter int SHIFT     = 10,
    parameter int ACC_WIDTH = 36
) (
    input  logic signed [ACC_WIDTH-1:0] sum,
    output logic        [DOUT_W-1:0]    result,
    output logic                        clamp
);

    localparam logic signed [ACC_WIDTH-1:0] ROUND =
        {{(ACC_WIDTH-1){1'b0}}, 1'b1} << (SHIFT - 1);
    localparam logic signed [ACC_WIDTH-1:0] MAX_W = ACC_WIDTH'(SAT_MAX);
    localparam logic signed [ACC_WIDTH-1:0] MIN_W = ACC_WIDTH'(SAT_MIN);

    logic signed [ACC_WIDTH-1:0] rounded;
    logic signed [ACC_WIDTH-1:0] shifted;
    logic signed [ACC_WIDTH-1:0] relu;

    assign rounded = sum + ROUND;
    assign shifted = rounded >>> SHIFT;

    always_comb begin
        relu = shifted;
`ifdef NETWORK_ACC_RELU_EN
        // ReLU clipping happens before saturation so it never counts as a clamp
        if (shifted[ACC_WIDTH-1]) begin
            relu = '0;
        end
`endif
    end

    always_comb begin
        result = relu[DOUT_W-1:0];
        clamp  = 1'b0;
        if (relu > MAX_W) begin
            result = DOUT_W'(SAT_MAX);
            clamp  = 1'b1;
        end else if (relu < MIN_W) begin
            result = DOUT_W'(SAT_MIN);
            clamp  = 1'b1;
        end
    end

endmodule

// File: rtl/network_acc_requant_28s_16s.sv
// ----------------------------------------------------------------------------
// network_acc_requant_28s_16s
// Accumulates NUM_TERMS signed 28-bit products per group, adds a per-group
// bias scaled by 2^SHIFT, rounds/shifts/saturates the result to 16 bits and
// hands it out through a valid/ready handshake. One result per group; groups
// never overlap (no term is accepted while a result is waiting).
//
// Optional feature macro: NETWORK_ACC_RELU_EN (ReLU before saturation,
// implemented in network_requant_sat).
//
// Ports:
//   clk        in   single clock, rising edge
//   reset      in   synchronous active-high reset
//   ce         in   clock enable; 0 freezes all state and ignores handshakes
//   din        in   [27:0] signed product
//   din_valid  in   din holds a valid product
//   din_ready  out  block accepts din this cycle (state ACCUM)
//   bias       in   [15:0] signed bias, sampled with the first term of a group
//   dout       out  [15:0] signed requantised result
//   dout_valid out  dout holds a valid result (state EMIT)
//   dout_ready in   consumer takes dout this cycle
//   sat        out  sticky flag, set whenever a result was clamped
// ----------------------------------------------------------------------------
module network_acc_requant_28s_16s
    import network_acc_requant_28s_16s_pkg::*;
#(
    parameter int NUM_TERMS = 9,
    parameter int SHIFT     = 10,
    parameter int ACC_WIDTH = 36
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                ce,
    input  logic [DIN_W-1:0]    din,
    input  logic                din_valid,
    output logic                din_ready,
    input  logic [BIAS_W-1:0]   bias,
    output logic [DOUT_W-1:0]   dout,
    output logic                dout_valid,
    input  logic                dout_ready,
    output logic                sat
);

    localparam int CNT_W = (NUM_TERMS > 1) ? $clog2(NUM_TERMS) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(NUM_TERMS - 1);

    state_t                      state_reg;
    logic        [CNT_W-1:0]     cnt_reg;
    logic signed [ACC_WIDTH-1:0] acc_reg;
    logic        [BIAS_W-1:0]    bias_reg;
    logic        [DOUT_W-1:0]    dout_reg;
    logic                        sat_reg;

    logic signed [ACC_WIDTH-1:0] din_ext;
    logic signed [ACC_WIDTH-1:0] acc_base;
    logic        [BIAS_W-1:0]    bias_sel;
    logic signed [ACC_WIDTH-1:0] bias_ext;
    logic signed [ACC_WIDTH-1:0] sum_next;
    logic        [DOUT_W-1:0]    rq_result;
    logic                        rq_clamp;
    logic                        first_term;
    logic                        last_term;

    assign first_term = (cnt_reg == '0);
    assign last_term  = (cnt_reg == LAST);

    assign din_ext  = {{(ACC_WIDTH-DIN_W){din[DIN_W-1]}}, din};

    // On the first term the accumulator and bias registers still hold the
    // previous group, so the closing sum must use the live inputs instead.
    // This is what makes NUM_TERMS=1 work (first and last term coincide).
    assign acc_base = first_term ? '0 : acc_reg;
    assign bias_sel = first_term ? bias : bias_reg;
    assign bias_ext = {{(ACC_WIDTH-BIAS_W){bias_sel[BIAS_W-1]}}, bias_sel};
    assign sum_next = acc_base + din_ext + (bias_ext <<< SHIFT);

    network_requant_sat #(
        .SHIFT     (SHIFT),
        .ACC_WIDTH (ACC_WIDTH)
    ) u_requant_sat (
        .sum    (sum_next),
        .result (rq_result),
        .clamp  (rq_clamp)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= ACCUM;
            cnt_reg   <= '0;
            acc_reg   <= '0;
            bias_reg  <= '0;
            dout_reg  <= '0;
            sat_reg   <= 1'b0;
        end else if (ce) begin
            case (state_reg)
                ACCUM: begin
                    if (din_valid) begin
                        if (first_term) begin
                            acc_reg  <= din_ext;
                            bias_reg <= bias;
                        end else begin
                            acc_reg  <= acc_reg + din_ext;
                        end
                        if (last_term) begin
                            cnt_reg   <= '0;
                            dout_reg  <= rq_result;
                            sat_reg   <= sat_reg | rq_clamp;
                            state_reg <= EMIT;
                        end else begin
                            cnt_reg   <= cnt_reg + CNT_W'(1);
                        end
                    end
                end
                EMIT: begin
                    // handoff edge: no term is taken here, din_ready is low
                    if (dout_ready) begin
                        state_reg <= ACCUM;
                    end
                end
                default: state_reg <= ACCUM;
            endcase
        end
    end

    assign din_ready  = (state_reg == ACCUM);
    assign dout_valid = (state_reg == EMIT);
    assign dout       = dout_reg;
    assign sat        = sat_reg;

endmodule

// File: tb/tb_network_acc_requant_28s_16s.sv
module tb_network_acc_requant_28s_16s;

    logic        clk = 1'b0;
    logic        reset;
    logic        ce;
    logic [27:0] din;
    logic        din_valid;
    logic        din_ready;
    logic [15:0] bias;
    logic [15:0] dout;
    logic        dout_valid;
    logic        dout_ready;
    logic        sat;

`ifdef NETWORK_ACC_RELU_EN
    localparam bit RELU = 1'b1;
`else
    localparam bit RELU = 1'b0;
`endif

    network_acc_requant_28s_16s #(
        .NUM_TERMS (3),
        .SHIFT     (10),
        .ACC_WIDTH (36)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .ce         (ce),
        .din        (din),
        .din_valid  (din_valid),
        .din_ready  (din_ready),
        .bias       (bias),
        .dout       (dout),
        .dout_valid (dout_valid),
        .dout_ready (dout_ready),
        .sat        (sat)
    );

    always #5 clk = ~clk;

    typedef struct {
        int t0;
        int t1;
        int t2;
        int b;
        int exp_d;
        bit exp_s;
    } vec_t;

    typedef struct {
        int d;
        bit s;
    } exp_t;

    exp_t sb[$];
    int   pass_cnt  = 0;
    int   total_cnt = 0;
    int   valid_run = 0;
    int   last_run  = 0;
    bit   ce_rand   = 1'b0;

    task automatic check(input string name, input int got, input int want);
        total_cnt++;
        if (got == want) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, got, want, $time);
        end
    endtask

    // scoreboard side: compare on every cycle where the handshake completes
    always @(negedge clk) begin
        if (reset) begin
            valid_run = 0;
        end else if (dout_valid) begin
            valid_run++;
            if (ce && dout_ready) begin
                if (sb.size() == 0) begin
                    check("unexpected_result", 1, 0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("dout", int'($signed(dout)), e.d);
                    check("sat", int'(sat), int'(e.s));
                end
                last_run  = valid_run;
                valid_run = 0;
            end
        end
    end

    task automatic send(input int v, input int b);
        int guard;
        guard     = 0;
        din       = 28'(v);
        bias      = 16'(b);
        din_valid = 1'b1;
        forever begin
            if (ce_rand) ce = 1'($urandom_range(0, 1));
            @(negedge clk);
            if (din_ready && ce) break;
            guard++;
            if (guard > 500) begin
                check("send_timeout", 0, 1);
                break;
            end
            @(posedge clk);
            #1;
        end
        @(posedge clk);
        #1;
        din_valid = 1'b0;
    endtask

    task automatic run_group(input int t0, input int t1, input int t2,
                             input int b, input int ed, input bit es);
        exp_t e;
        e.d = ed;
        e.s = es;
        sb.push_back(e);
        send(t0, b);
        send(t1, -7777);   // bias must only be taken from the first term
        send(t2, 12345);
    endtask

    task automatic drain();
        int guard;
        guard = 0;
        while (sb.size() != 0 && guard < 500) begin
            @(posedge clk);
            #1;
            if (ce_rand) ce = 1'($urandom_range(0, 1));
            guard++;
        end
        check("drain_timeout", sb.size(), 0);
        ce = 1'b1;
        @(posedge clk);
        #1;
    endtask

    function automatic int model(input int t0, input int t1, input int t2, input int b);
        longint s;
        longint r;
        s = longint'(t0) + longint'(t1) + longint'(t2) + longint'(b) * 1024 + 512;
        r = s >>> 10;
        if (RELU && r < 0) r = 0;
        if (r > 32767) r = 32767;
        if (r < -32768) r = -32768;
        return int'(r);
    endfunction

    vec_t vecs[12];

    initial begin
        vecs[0]  = '{1024, 2048, 3072, 0, 6, 1'b0};
        vecs[1]  = '{512, 512, 512, 0, 2, 1'b0};
        vecs[2]  = '{-512, -512, -512, 0, RELU ? 0 : -1, 1'b0};
        vecs[3]  = '{512, 0, 0, 0, 1, 1'b0};
        vecs[4]  = '{511, 0, 0, 0, 0, 1'b0};
        vecs[5]  = '{-513, 0, 0, 0, RELU ? 0 : -1, 1'b0};
        vecs[6]  = '{500, 0, 0, -1, RELU ? 0 : -1, 1'b0};
        vecs[7]  = '{0, 0, 0, 32767, 32767, 1'b0};
        vecs[8]  = '{134217727, 134217727, 134217727, 0, 32767, 1'b1};
        vecs[9]  = '{0, 0, 0, 5, 5, 1'b1};
        vecs[10] = '{1023, 0, 0, 32767, 32767, 1'b1};
        vecs[11] = '{-134217728, -134217728, -134217728, 0, RELU ? 0 : -32768, 1'b1};

        reset      = 1'b1;
        ce         = 1'b1;
        din        = '0;
        din_valid  = 1'b0;
        bias       = '0;
        dout_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check("rst_din_ready", int'(din_ready), 1);
        check("rst_dout_valid", int'(dout_valid), 0);
        check("rst_dout", int'(dout), 0);
        check("rst_sat", int'(sat), 0);
        @(posedge clk);
        #1;

        // first group by hand: result appears the cycle after the 3rd accept
        // and stays valid exactly one cycle with dout_ready held high
        begin
            exp_t e;
            e.d = 6;
            e.s = 1'b0;
            check("pre_valid", int'(dout_valid), 0);
            sb.push_back(e);
            send(1024, 0);
            send(2048, 0);
            check("mid_valid", int'(dout_valid), 0);
            send(3072, 0);
            @(negedge clk);
            check("latency_valid", int'(dout_valid), 1);
            @(posedge clk);
            #1;
            drain();
            check("valid_cycles", last_run, 1);
        end

        for (int i = 0; i < 12; i++) begin
            run_group(vecs[i].t0, vecs[i].t1, vecs[i].t2, vecs[i].b,
                      vecs[i].exp_d, vecs[i].exp_s);
        end
        drain();

        // back-pressure: result held while a term waits on din
        dout_ready = 1'b0;
        run_group(100, 200, 300, 0, 1, 1'b1);   // 600+512 -> 1
        din       = 28'(777);
        bias      = 16'(0);
        din_valid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("hold_valid", int'(dout_valid), 1);
            check("hold_dout", int'($signed(dout)), 1);
            check("hold_din_ready", int'(din_ready), 0);
        end
        @(posedge clk);
        #1;
        dout_ready = 1'b1;
        run_group(777, 247, 0, 0, 1, 1'b1);     // 1024+512 -> 1
        drain();

        // reset mid-group, with ce low: partial group is discarded
        send(100000, 0);
        send(200000, 0);
        ce    = 1'b0;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        ce    = 1'b1;
        @(negedge clk);
        check("rst2_sat", int'(sat), 0);
        check("rst2_dout", int'(dout), 0);
        check("rst2_din_ready", int'(din_ready), 1);
        @(posedge clk);
        #1;
        run_group(1024, 1024, 1024, 0, 3, 1'b0);
        drain();

        // reset while a result waits in EMIT
        dout_ready = 1'b0;
        run_group(2048, 0, 0, 0, 2, 1'b0);
        begin
            int guard;
            guard = 0;
            while (!dout_valid && guard < 20) begin
                @(negedge clk);
                guard++;
            end
            check("emit_reached", int'(dout_valid), 1);
        end
        @(posedge clk);
        #1;
        reset = 1'b1;
        void'(sb.pop_front());
        @(posedge clk);
        #1;
        reset      = 1'b0;
        dout_ready = 1'b1;
        @(negedge clk);
        check("rst3_dout_valid", int'(dout_valid), 0);
        check("rst3_dout", int'(dout), 0);
        @(posedge clk);
        #1;

        // random clock-enable gaps must not change results
        ce_rand = 1'b1;
        run_group(1024, 1024, 1024, 0, 3, 1'b0);
        for (int g = 0; g < 4; g++) begin
            int a0;
            int a1;
            int a2;
            int bb;
            a0 = $urandom_range(0, 200000) - 100000;
            a1 = $urandom_range(0, 200000) - 100000;
            a2 = $urandom_range(0, 200000) - 100000;
            bb = $urandom_range(0, 200) - 100;
            run_group(a0, a1, a2, bb, model(a0, a1, a2, bb), 1'b0);
        end
        drain();
        ce_rand = 1'b0;

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
